sdram_rr_arbiter: RTL
=====================

// Module: sdram_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one sdram_interface among NUM_REQ requesters.
//  Accepts one command at a time, holds it on the controller port until taken,
//  and routes the read data beats back to the requester that issued the read.
//  Sits between the client blocks and the SDRAM controller in the memory subsystem.
// PARAMETERS
//  NUM_REQ      4   number of requesters, 2..8
//  BURST_LENGTH 1   read beats per read command; must match the controller (1,2,4,8)
//  RD_TIMEOUT   64  max cycles from acceptance to the last read beat before abort
// PORTS
//  clk          in   1            clock, shared with the controller
//  reset        in   1            asynchronous, active-high
//  req_read     in   NUM_REQ      per-requester read request, level, held until grant
//  req_write    in   NUM_REQ      per-requester write request, level, held until grant
//  req_addr     in   NUM_REQ*25   packed addresses; slice i = [25*i +: 25]
//  req_wdata    in   NUM_REQ*16   packed write data; slice i = [16*i +: 16]
//  req_grant    out  NUM_REQ      one-hot 1-cycle pulse: command i taken by arbiter
//  req_rvalid   out  NUM_REQ      one-hot: rdata is a read beat for requester i
//  req_rdata    out  16           shared read data bus
//  rd_timeout   out  1            1-cycle pulse: read aborted by timeout
//  owner        out  log2(NUM_REQ) index of the last granted requester
//  busy         out  1            arbiter is not in IDLE
//  mem_ready    in   1            controller ready
//  mem_valid    in   1            controller read data valid
//  mem_rdata    in   16           controller data_out
//  mem_read     out  1            controller read
//  mem_write    out  1            controller write
//  mem_addr     out  25           controller address
//  mem_wdata    out  16           controller data_in
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, round-robin pointer 0, beat and timeout counters 0.
//  Reset mid-operation is a full abort. No beat is delivered after reset.
//  A requester is eligible when it has req_read|req_write set.
//  If both are set, it is treated as a read. The write stays pending until a later grant.
//  FSM states: IDLE, ISSUE, WAIT_DATA.
//  IDLE: when mem_ready=1 and at least one requester is eligible:
//   - pick the first eligible requester at or after the pointer (wrapping modulo NUM_REQ).
//   - register its address and data onto mem_addr/mem_wdata.
//   - assert mem_read or mem_write (never both).
//   - pulse req_grant[i], set owner=i, set the pointer to (i+1) mod NUM_REQ.
//   - go to ISSUE.
//  Grant latency: 1 cycle from the sampled request and mem_ready.
//  With no eligible requester or mem_ready=0, the FSM stays in IDLE and all mem_* strobes are 0.
//  ISSUE: hold mem_read/mem_write and mem_addr/mem_wdata stable while mem_ready=1.
//   - The first cycle mem_ready=0 means the command was accepted.
//   - On that cycle drop the strobe.
//   - A write returns to IDLE.
//   - A read clears the beat counter, starts the timeout counter and goes to WAIT_DATA.
//  WAIT_DATA: each mem_valid=1 cycle forwards one beat:
//   - req_rdata = mem_rdata (registered, 1 cycle after mem_valid).
//   - req_rvalid[owner] = 1 in that same cycle.
//   - After BURST_LENGTH beats, go to IDLE.
//   - If the timeout counter reaches RD_TIMEOUT first: pulse rd_timeout, go to IDLE,
//     and drop any beats still arriving (no req_rvalid).
//  No new command is issued while in ISSUE or WAIT_DATA. Only one transaction is in flight.
//  req_rvalid bits are 0 outside forwarded beats. req_rdata holds its last value.
//  busy = (state != IDLE).
//  The pointer advances only on a grant. A requester with a continuous request is
//  served at least once every NUM_REQ grants.
// TESTING
//  Single read: req_read[0]=1, addr 0x0001234, controller returns 0xBEEF.
//   -> one req_grant[0] pulse, mem_read held until mem_ready falls,
//      then one req_rvalid[0] with rdata=0xBEEF.
//  Contention: req_read[0..3] all held high.
//   -> grant order 0,1,2,3,0. Each rvalid goes only to the matching owner.
//  Write: req_write[2]=1, addr 0x1ABCDEF, data 0x5A5A.
//   -> mem_write=1, mem_addr=0x1ABCDEF, mem_wdata=0x5A5A.
//      No rvalid. busy=0 one cycle after mem_ready falls.
//  Both read and write set on requester 1.
//   -> mem_read issued first. A second grant then issues the write (if still held).
//  Read timeout: no mem_valid after acceptance.
//   -> rd_timeout pulse after RD_TIMEOUT cycles, FSM back in IDLE, a late mem_valid is ignored.
//  Reset in WAIT_DATA, and burst: BURST_LENGTH=4.
//   -> reset: all outputs 0, pointer 0.
//   -> burst: exactly 4 req_rvalid pulses before the next grant.

Source files
------------

// File: rtl/sdram_rr_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port among NUM_REQ clients.
// Exactly one command is in flight; read beats are steered back to the issuing client.
module sdram_rr_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int BURST_LENGTH = 1,
   parameter int RD_TIMEOUT   = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_read,
   input  logic [NUM_REQ-1:0]         req_write,
   input  logic [NUM_REQ*25-1:0]      req_addr,
   input  logic [NUM_REQ*16-1:0]      req_wdata,
   output logic [NUM_REQ-1:0]         req_grant,
   output logic [NUM_REQ-1:0]         req_rvalid,
   output logic [15:0]                req_rdata,
   output logic                       rd_timeout,
   output logic [$clog2(NUM_REQ)-1:0] owner,
   output logic                       busy,
   input  logic                       mem_ready,
   input  logic                       mem_valid,
   input  logic [15:0]                mem_rdata,
   output logic                       mem_read,
   output logic                       mem_write,
   output logic [24:0]                mem_addr,
   output logic [15:0]                mem_wdata
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int BW = $clog2(BURST_LENGTH + 1);
   localparam int TW = $clog2(RD_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA} state_t;

   state_t               state;
   logic [IW-1:0]        ptr;
   logic                 is_read;
   logic [BW-1:0]        beat_cnt;
   logic [TW-1:0]        to_cnt;

   logic [NUM_REQ-1:0]   eligible;
   logic                 found_hi, found_lo, found;
   logic [IW-1:0]        pick_hi, pick_lo, pick;
   logic [24:0]          sel_addr;
   logic [15:0]          sel_wdata;
   logic                 sel_read;

   assign eligible = req_read | req_write;
   assign busy     = (state != IDLE);

   // Two-pass search: first eligible at/after the pointer, else the first one below it.
   always_comb begin
      found_hi  = 1'b0;
      found_lo  = 1'b0;
      pick_hi   = '0;
      pick_lo   = '0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_read  = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found_hi && eligible[k] && (IW'(k) >= ptr)) begin
            found_hi = 1'b1;
            pick_hi  = IW'(k);
         end
         if (!found_lo && eligible[k]) begin
            found_lo = 1'b1;
            pick_lo  = IW'(k);
         end
      end
      found = found_hi | found_lo;
      pick  = found_hi ? pick_hi : pick_lo;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (pick == IW'(k)) begin
            sel_addr  = req_addr[25*k +: 25];
            sel_wdata = req_wdata[16*k +: 16];
            sel_read  = req_read[k];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         ptr        <= '0;
         owner      <= '0;
         is_read    <= 1'b0;
         beat_cnt   <= '0;
         to_cnt     <= '0;
         req_grant  <= '0;
         req_rvalid <= '0;
         req_rdata  <= '0;
         rd_timeout <= 1'b0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         req_grant  <= '0;
         req_rvalid <= '0;
         rd_timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (mem_ready && found) begin
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_wdata;
                  mem_read  <= sel_read;
                  mem_write <= ~sel_read;
                  is_read   <= sel_read;
                  req_grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
                  owner     <= pick;
                  if (pick == IW'(NUM_REQ - 1)) ptr <= '0;
                  else                          ptr <= pick + 1'b1;
                  state     <= ISSUE;
               end
            end
            // Controller dropping ready is the acceptance handshake.
            ISSUE: begin
               if (!mem_ready) begin
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  if (is_read) begin
                     beat_cnt <= '0;
                     to_cnt   <= '0;
                     state    <= WAIT_DATA;
                  end else begin
                     state    <= IDLE;
                  end
               end
            end
            WAIT_DATA: begin
               if (mem_valid) begin
                  req_rdata  <= mem_rdata;
                  req_rvalid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
                  beat_cnt   <= beat_cnt + 1'b1;
               end
               if (mem_valid && (beat_cnt == BW'(BURST_LENGTH - 1))) begin
                  state <= IDLE;
               end else if (to_cnt == TW'(RD_TIMEOUT - 1)) begin
                  rd_timeout <= 1'b1;
                  state      <= IDLE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
